// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Recovers the value shown on a multiplexed 8-digit, active-low 7-segment
//   display by watching the segment and anode lines. A digit is captured once
//   its segment/anode pattern has been stable for STABLE_CYCLES samples. When
//   all eight digits have been captured, the assembled frame is published.
//
// Parameters
//   STABLE_CYCLES  : identical consecutive samples needed to capture (1..255)
//   TIMEOUT_CYCLES : capture-free cycles before stale asserts (1..2^20-1)
//
// Ports
//   clk         : clock, rising edge
//   RST         : asynchronous reset, active low
//   SEG[7:0]    : active-low segments, [0]=a .. [6]=g, [7]=dp
//   AN[7:0]     : active-low digit enables, AN[i]=0 selects digit i
//   value[31:0] : last complete frame, digit i in value[4i+3:4i]
//   dp[7:0]     : last complete frame decimal points (1 = lit)
//   frame_valid : one-cycle pulse when value/dp/err update
//   err[7:0]    : digit i held an undecodable pattern in the last frame
//   seen[7:0]   : digits captured so far in the frame under assembly
//   stale       : no capture for TIMEOUT_CYCLES cycles
`timescale 1ns/1ps
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [7:0]  SEG,
  input  logic [7:0]  AN,
  output logic [31:0] value,
  output logic [7:0]  dp,
  output logic        frame_valid,
  output logic [7:0]  err,
  output logic [7:0]  seen,
  output logic        stale
);

  typedef enum logic [1:0] {BLANK, SETTLE, HOLD} state_t;

  localparam logic [7:0]  STABLE_LAST = 8'(STABLE_CYCLES);
  localparam logic [19:0] TIMEOUT_MAX = 20'(TIMEOUT_CYCLES);

  // True when exactly one anode line is driven low.
  function automatic logic is_one_hot_low(input logic [7:0] an);
    logic [3:0] zeros;
    zeros = 4'd0;
    for (int k = 0; k < 8; k++) zeros = zeros + {3'b000, ~an[k]};
    return (zeros == 4'd1);
  endfunction

  // Index of the low anode line (only meaningful for a one-hot sample).
  function automatic logic [2:0] low_index(input logic [7:0] an);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 0; k < 8; k++) if (!an[k]) idx = 3'(k);
    return idx;
  endfunction

  // {error, nibble} for an active-high gfedcba pattern.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    case (pat)
      7'h3F: decode_seg = 5'h00;
      7'h06: decode_seg = 5'h01;
      7'h5B: decode_seg = 5'h02;
      7'h4F: decode_seg = 5'h03;
      7'h66: decode_seg = 5'h04;
      7'h6D: decode_seg = 5'h05;
      7'h7D: decode_seg = 5'h06;
      7'h07: decode_seg = 5'h07;
      7'h7F: decode_seg = 5'h08;
      7'h6F: decode_seg = 5'h09;
      7'h77: decode_seg = 5'h0A;
      7'h7C: decode_seg = 5'h0B;
      7'h39: decode_seg = 5'h0C;
      7'h5E: decode_seg = 5'h0D;
      7'h79: decode_seg = 5'h0E;
      7'h71: decode_seg = 5'h0F;
      default: decode_seg = 5'h10;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  s_seg_q, s_an_q, prev_seg_q, prev_an_q;
  logic [7:0]  stable_cnt_q, stable_cnt_d;
  logic [19:0] idle_q, idle_d;
  logic [31:0] sh_val_q, sh_val_d;
  logic [7:0]  sh_dp_q, sh_dp_d, sh_err_q, sh_err_d;
  logic [7:0]  seen_q, seen_d;
  logic [31:0] value_q, value_d;
  logic [7:0]  dp_q, dp_d, err_q, err_d;
  logic        fv_q, fv_d, stale_q, stale_d;

  logic        one_hot, same, capture, publish;
  logic [2:0]  slot;
  logic [4:0]  dec;

  assign one_hot = is_one_hot_low(s_an_q);
  assign same    = (s_seg_q == prev_seg_q) && (s_an_q == prev_an_q);
  assign slot    = low_index(s_an_q);
  assign dec     = decode_seg(~s_seg_q[6:0]);
  assign publish = (seen_q == 8'hFF);

  always_comb begin
    state_d      = state_q;
    stable_cnt_d = stable_cnt_q;
    capture      = 1'b0;
    case (state_q)
      BLANK: begin
        if (one_hot) begin
          stable_cnt_d = 8'd1;
          // A single stable sample already satisfies STABLE_CYCLES=1.
          if (STABLE_LAST == 8'd1) begin
            capture = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (same) begin
          stable_cnt_d = stable_cnt_q + 8'd1;
          if (stable_cnt_q + 8'd1 == STABLE_LAST) begin
            capture = 1'b1;
            state_d = HOLD;
          end
        end else if (one_hot) begin
          stable_cnt_d = 8'd1;
          if (STABLE_LAST == 8'd1) begin
            capture = 1'b1;
            state_d = HOLD;
          end
        end else begin
          stable_cnt_d = 8'd0;
          state_d      = BLANK;
        end
      end
      HOLD: begin
        if (!same) begin
          if (one_hot) begin
            stable_cnt_d = 8'd1;
            if (STABLE_LAST == 8'd1) begin
              capture = 1'b1;
            end else begin
              state_d = SETTLE;
            end
          end else begin
            stable_cnt_d = 8'd0;
            state_d      = BLANK;
          end
        end
      end
      default: begin
        stable_cnt_d = 8'd0;
        state_d      = BLANK;
      end
    endcase
  end

  always_comb begin
    sh_val_d = sh_val_q;
    sh_dp_d  = sh_dp_q;
    sh_err_d = sh_err_q;
    // A full seen mask is published and cleared on this edge; a capture in
    // the same cycle becomes the first digit of the next frame.
    seen_d   = publish ? 8'h00 : seen_q;
    if (capture) begin
      sh_val_d[4*slot +: 4] = dec[3:0];
      sh_dp_d[slot]         = ~s_seg_q[7];
      sh_err_d[slot]        = dec[4];
      seen_d[slot]          = 1'b1;
    end
    value_d = publish ? sh_val_q : value_q;
    dp_d    = publish ? sh_dp_q  : dp_q;
    err_d   = publish ? sh_err_q : err_q;
    fv_d    = publish;
    if (capture)                  idle_d = 20'd0;
    else if (idle_q == TIMEOUT_MAX) idle_d = idle_q;
    else                          idle_d = idle_q + 20'd1;
    stale_d = (idle_d == TIMEOUT_MAX);
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q      <= BLANK;
      s_seg_q      <= 8'hFF;
      s_an_q       <= 8'hFF;
      prev_seg_q   <= 8'hFF;
      prev_an_q    <= 8'hFF;
      stable_cnt_q <= 8'd0;
      idle_q       <= 20'd0;
      sh_val_q     <= 32'd0;
      sh_dp_q      <= 8'd0;
      sh_err_q     <= 8'd0;
      seen_q       <= 8'd0;
      value_q      <= 32'd0;
      dp_q         <= 8'd0;
      err_q        <= 8'd0;
      fv_q         <= 1'b0;
      stale_q      <= 1'b0;
    end else begin
      // Input capture stage; prev_* holds the sample before the current one.
      s_seg_q      <= SEG;
      s_an_q       <= AN;
      prev_seg_q   <= s_seg_q;
      prev_an_q    <= s_an_q;
      // Decode / frame assembly stage.
      state_q      <= state_d;
      stable_cnt_q <= stable_cnt_d;
      idle_q       <= idle_d;
      sh_val_q     <= sh_val_d;
      sh_dp_q      <= sh_dp_d;
      sh_err_q     <= sh_err_d;
      seen_q       <= seen_d;
      value_q      <= value_d;
      dp_q         <= dp_d;
      err_q        <= err_d;
      fv_q         <= fv_d;
      stale_q      <= stale_d;
    end
  end

  assign value       = value_q;
  assign dp          = dp_q;
  assign err         = err_q;
  assign frame_valid = fv_q;
  assign seen        = seen_q;
  assign stale       = stale_q;

endmodule
